// File: rtl/instr_mem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states and checksum width.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int CSUM_WIDTH = 8;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host byte stream, load control, memory write port and status of the loader.
interface instr_mem_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 13
);
  logic                  START;
  logic [ADDR_WIDTH-1:0] START_ADDR;
  logic [LEN_WIDTH-1:0]  LEN;
  logic [7:0]            IN_DATA;
  logic                  IN_VALID;
  logic                  IN_READY;
  logic                  MEM_WE;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [7:0]            MEM_WDATA;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;
  logic                  CPU_HOLD;

  // Host / debug side: drives the stream and load control, observes the rest.
  modport master (
    output START, START_ADDR, LEN, IN_DATA, IN_VALID,
    input  IN_READY, MEM_WE, MEM_ADDR, MEM_WDATA, BUSY, DONE, ERR, CPU_HOLD
  );

  // Loader side.
  modport slave (
    input  START, START_ADDR, LEN, IN_DATA, IN_VALID,
    output IN_READY, MEM_WE, MEM_ADDR, MEM_WDATA, BUSY, DONE, ERR, CPU_HOLD
  );
endinterface

// File: rtl/instr_mem_loader_byte_checksum8.sv
// Running mod-256 byte sum with clear/add and a test for "sum plus data is zero".
module byte_checksum8
  import instr_mem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  add,
  input  logic [CSUM_WIDTH-1:0] data,
  output logic                  zero
);

  logic [CSUM_WIDTH-1:0] sum_q, sum_d;
  logic [CSUM_WIDTH-1:0] trial;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = sum_q + data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  // Evaluated against the incoming byte so the checksum verdict lands on its handshake edge.
  assign trial = sum_q + data;
  assign zero  = (trial == '0);

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program image into byte memory, verifies the trailing checksum and
// releases the core from reset only after a good image is loaded.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096,
  parameter int LEN_WIDTH  = 13
) (
  input  logic              CLK,
  input  logic              RESET_N,
  instr_mem_loader_if.slave bus
);

  localparam int EXT_W = ADDR_WIDTH + 1;
  localparam logic [EXT_W-1:0] DEPTH_EXT = EXT_W'(MEM_DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  hold_q, hold_d;

  logic                  hs;
  logic                  sum_clr;
  logic                  sum_add;
  logic                  sum_zero;
  logic [EXT_W-1:0]      end_ext;

  assign hs      = bus.IN_VALID && ready_q;
  // One extra bit so an image reaching past the top of memory cannot wrap into range.
  assign end_ext = {1'b0, bus.START_ADDR} + EXT_W'(bus.LEN);

  byte_checksum8 u_csum (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (sum_clr),
    .add   (sum_add),
    .data  (bus.IN_DATA),
    .zero  (sum_zero)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    ready_d    = ready_q;
    we_d       = 1'b0;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    sum_clr    = 1'b0;
    sum_add    = 1'b0;

    case (state_q)
      IDLE, FINISH: begin
        if (bus.START) begin
          addr_d   = bus.START_ADDR;
          remain_d = bus.LEN;
          done_d   = 1'b0;
          err_d    = 1'b0;
          sum_clr  = 1'b1;
          if (end_ext > DEPTH_EXT) begin
            err_d   = 1'b1;
            state_d = FINISH;
            ready_d = 1'b0;
            busy_d  = 1'b0;
          end else if (bus.LEN == '0) begin
            state_d = CHECK;
            ready_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = LOAD;
            ready_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end

      LOAD: begin
        if (hs) begin
          we_d       = 1'b1;
          mem_addr_d = addr_q;
          wdata_d    = bus.IN_DATA;
          sum_add    = 1'b1;
          addr_d     = addr_q + ADDR_WIDTH'(1);
          remain_d   = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        // The checksum byte only feeds the verdict; it is never written.
        if (hs) begin
          if (sum_zero) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = FINISH;
          ready_d = 1'b0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    hold_d = !done_d;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.IN_READY  = ready_q;
  assign bus.MEM_WE    = we_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_WDATA = wdata_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  assign bus.CPU_HOLD  = hold_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: image loads, checksum verdicts, range
// rejection, handshake gaps and asynchronous reset mid-load.
module tb_instr_mem_loader;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_pass   = 0;

  int         wa[$];
  int         wd[$];
  logic [7:0] mem [0:4095];

  instr_mem_loader_if #(.ADDR_WIDTH(32), .LEN_WIDTH(13)) bus ();

  instr_mem_loader #(
    .ADDR_WIDTH (32),
    .MEM_DEPTH  (4096),
    .LEN_WIDTH  (13)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every MEM_WE pulse spans exactly one cycle, so one negedge sees it once.
  always @(negedge clk) begin
    if (bus.MEM_WE === 1'b1) begin
      wa.push_back(int'(bus.MEM_ADDR));
      wd.push_back(int'(bus.MEM_WDATA));
      if (bus.MEM_ADDR < 32'd4096) mem[bus.MEM_ADDR[11:0]] <= bus.MEM_WDATA;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  // Called at edge+1; returns at edge+1 after the START edge.
  task automatic start(input logic [31:0] a, input logic [12:0] l);
    bus.START_ADDR = a;
    bus.LEN        = l;
    bus.START      = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
  endtask

  // Holds IN_VALID until a handshake edge has passed; returns at edge+1.
  task automatic send_byte(input logic [7:0] d);
    logic r;
    bit   got_hs;
    got_hs       = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = d;
    for (int k = 0; k < 20 && !got_hs; k++) begin
      r = bus.IN_READY;
      @(posedge clk);
      #1;
      if (r === 1'b1) got_hs = 1'b1;
    end
    if (!got_hs) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_valid();
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'h00;
  endtask

  task automatic check_writes(input string tag, input int base, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] exp_d[4];
    exp_d = '{d0, d1, d2, d3};
    check({tag, "_count"}, wa.size(), 4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wa[i], base + i);
      check($sformatf("%s_data%0d", tag, i), wd[i], {24'd0, exp_d[i]});
    end
  endtask

  bit pat[6];
  logic [7:0] vdata[4];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst_n          = 1'b0;
    bus.START      = 1'b0;
    bus.START_ADDR = '0;
    bus.LEN        = '0;
    idle_valid();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.IN_READY, 0);
    check("rst_we",    bus.MEM_WE,   0);
    check("rst_addr",  bus.MEM_ADDR, 0);
    check("rst_wdata", bus.MEM_WDATA, 0);
    check("rst_busy",  bus.BUSY,     0);
    check("rst_done",  bus.DONE,     0);
    check("rst_err",   bus.ERR,      0);
    check("rst_hold",  bus.CPU_HOLD, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good 4-byte image at 0.
    clear_log();
    start(32'd0, 13'd4);
    check("t1_ready_after_start", bus.IN_READY, 1);
    check("t1_busy_after_start",  bus.BUSY,     1);
    send_byte(8'h01);
    check("t1_first_we",   bus.MEM_WE,    1);
    check("t1_first_addr", bus.MEM_ADDR,  0);
    check("t1_first_data", bus.MEM_WDATA, 8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check("t1_last_we_in_check", bus.MEM_WE, 1);
    send_byte(8'hF6);
    idle_valid();
    check("t1_done",  bus.DONE,     1);
    check("t1_err",   bus.ERR,      0);
    check("t1_hold",  bus.CPU_HOLD, 0);
    check("t1_ready", bus.IN_READY, 0);
    check("t1_busy",  bus.BUSY,     0);
    check_writes("t1", 0, 8'h01, 8'h02, 8'h03, 8'h04);

    // Same image, bad checksum.
    clear_log();
    start(32'd0, 13'd4);
    check("t2_hold_rearmed", bus.CPU_HOLD, 1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'hF5);
    idle_valid();
    check("t2_err",  bus.ERR,      1);
    check("t2_done", bus.DONE,     0);
    check("t2_hold", bus.CPU_HOLD, 1);
    check("t2_count", wa.size(), 4);

    // Out-of-range image.
    clear_log();
    start(32'd4094, 13'd4);
    check("t3_err",   bus.ERR,      1);
    check("t3_busy",  bus.BUSY,     0);
    check("t3_ready", bus.IN_READY, 0);
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    idle_valid();
    check("t3_ready_stays", bus.IN_READY, 0);
    check("t3_no_writes",   wa.size(),    0);

    // Image ending exactly at the last byte of memory.
    clear_log();
    start(32'd4092, 13'd4);
    check("t3b_err", bus.ERR, 0);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
    send_byte(8'h60);
    idle_valid();
    check("t3b_done", bus.DONE, 1);
    check_writes("t3b", 4092, 8'h10, 8'h20, 8'h30, 8'h40);

    // Empty images.
    clear_log();
    start(32'h10, 13'd0);
    check("t4_ready", bus.IN_READY, 1);
    send_byte(8'h00);
    idle_valid();
    check("t4_done",   bus.DONE,  1);
    check("t4_writes", wa.size(), 0);
    start(32'h10, 13'd0);
    check("t4_done_cleared", bus.DONE,     0);
    check("t4_hold_set",     bus.CPU_HOLD, 1);
    send_byte(8'h01);
    idle_valid();
    check("t4_err",  bus.ERR,  1);
    check("t4_done2", bus.DONE, 0);

    // Gapped valid with an ignored START mid-load.
    clear_log();
    pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vdata = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    start(32'h100, 13'd4);
    begin
      int k;
      k = 0;
      for (int i = 0; i < 6; i++) begin
        bus.IN_VALID   = pat[i];
        bus.IN_DATA    = pat[i] ? vdata[k] : 8'hEE;
        bus.START      = (i == 2);
        bus.START_ADDR = 32'd0;
        bus.LEN        = 13'd1;
        @(posedge clk);
        #1;
        if (pat[i]) k++;
      end
    end
    bus.START = 1'b0;
    check("t5_in_check", bus.BUSY, 1);
    send_byte(8'h76);
    idle_valid();
    check("t5_done", bus.DONE, 1);
    check_writes("t5", 32'h100, 8'hA1, 8'hA2, 8'hA3, 8'hA4);

    // Asynchronous reset after two bytes.
    clear_log();
    start(32'h200, 13'd4);
    send_byte(8'h11);
    send_byte(8'h22);
    check("t6_we_before_rst", bus.MEM_WE, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_we",    bus.MEM_WE,   0);
    check("t6_ready", bus.IN_READY, 0);
    check("t6_busy",  bus.BUSY,     0);
    check("t6_addr",  bus.MEM_ADDR, 0);
    check("t6_hold",  bus.CPU_HOLD, 1);
    idle_valid();
    @(negedge clk);
    check("t6_writes", wa.size(), 1);
    check("t6_mem0",   mem[12'h200], 8'h11);
    check("t6_mem1",   mem[12'h201], 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start(32'h300, 13'd2);
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'hF5);
    idle_valid();
    check("t6_done_after", bus.DONE,     1);
    check("t6_hold_after", bus.CPU_HOLD, 0);
    check("t6_mem300",     mem[12'h300], 8'h05);
    check("t6_mem301",     mem[12'h301], 8'h06);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
